fib_index_finder: RTL and testbench

//  Inverse of the Fibonacci generator: accepts a WIDTH-bit value and iterates the sequence
//  F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2) until it reaches or passes that value.

---
 rtl/fib_index_if.sv | 18 +
 rtl/fib_index_finder.sv | 104 ++++++++++
 tb/tb_fib_index_finder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fib_index_if.sv
// fib_index_if: request/result bundle for fib_index_finder.
// The abort signal exists only when FIB_INDEX_ABORT_EN is defined.
interface fib_index_if #(parameter int WIDTH = 32, parameter int IDX_W = 6);
  logic             start;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             done;
  logic             is_fib;
  logic [IDX_W-1:0] index;
`ifdef FIB_INDEX_ABORT_EN
  logic             abort;
  modport master (output start, value, abort, input busy, done, is_fib, index);
  modport slave  (input start, value, abort, output busy, done, is_fib, index);
`else
  modport master (output start, value, input busy, done, is_fib, index);
  modport slave  (input start, value, output busy, done, is_fib, index);
`endif
endinterface

// File: rtl/fib_index_finder.sv
// fib_index_finder: maps a WIDTH-bit value to its exact (hit) or floor (miss) Fibonacci index.
// Define FIB_INDEX_ABORT_EN to add bus.abort, which cancels a running search without a done pulse.
module fib_index_finder #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6
) (
  input logic        clock,
  input logic        rst,
  fib_index_if.slave bus
);
  typedef enum logic {IDLE, SEARCH} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] prev, cur, target, prev_n, cur_n, target_n;
  logic [IDX_W-1:0] idx, idx_n, index_q, index_n;
  logic             busy_q, busy_n, done_q, done_n, fib_q, fib_n;
  logic [WIDTH:0]   sum;
  logic             abort_req;
`ifdef FIB_INDEX_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif
  // carry bit flags that the next term no longer fits in WIDTH bits
  assign sum = {1'b0, cur} + {1'b0, prev};
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      prev    <= '0;
      cur     <= '0;
      target  <= '0;
      idx     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fib_q   <= 1'b0;
      index_q <= '0;
    end else begin
      state   <= state_n;
      prev    <= prev_n;
      cur     <= cur_n;
      target  <= target_n;
      idx     <= idx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      fib_q   <= fib_n;
      index_q <= index_n;
    end
  end
  always_comb begin
    state_n  = state;
    prev_n   = prev;
    cur_n    = cur;
    target_n = target;
    idx_n    = idx;
    busy_n   = busy_q;
    done_n   = 1'b0;
    fib_n    = fib_q;
    index_n  = index_q;
    if (state == IDLE) begin
      if (bus.start) begin
        target_n = bus.value;
        prev_n   = '0;
        cur_n    = WIDTH'(1);
        idx_n    = IDX_W'(1);
        if (bus.value == '0) begin
          done_n  = 1'b1;
          fib_n   = 1'b1;
          index_n = '0;
        end else begin
          state_n = SEARCH;
          busy_n  = 1'b1;
        end
      end
    end else if (abort_req) begin
      state_n = IDLE;
      busy_n  = 1'b0;
    end else if (cur == target) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      done_n  = 1'b1;
      fib_n   = 1'b1;
      index_n = idx;
    end else if (cur > target) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      done_n  = 1'b1;
      fib_n   = 1'b0;
      index_n = idx - IDX_W'(1);
    end else if (sum[WIDTH]) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      done_n  = 1'b1;
      fib_n   = 1'b0;
      index_n = idx;
    end else begin
      prev_n = cur;
      cur_n  = sum[WIDTH-1:0];
      idx_n  = idx + IDX_W'(1);
    end
  end
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.is_fib = fib_q;
  assign bus.index  = index_q;
endmodule

// File: tb/tb_fib_index_finder.sv
// tb_fib_index_finder: directed and randomized checks of fib_index_finder against a table-based model.
module tb_fib_index_finder;
  logic   clock = 1'b0;
  logic   rst   = 1'b0;
  int     checks = 0;
  int     errors = 0;
  longint fib_tab [49];
  logic   last_fib = 1'b0;
  int     last_idx = 0;

  fib_index_if #(.WIDTH(32), .IDX_W(6)) bus ();
  fib_index_finder #(.WIDTH(32), .IDX_W(6)) dut (.clock(clock), .rst(rst), .bus(bus.slave));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // hit: smallest k>=1 with F(k)==v; miss: largest F(k)<v; values above F(47) overflow at edge 47
  function automatic void ref_model(input longint v, output logic efib, output int eidx, output int elat);
    efib = 1'b0;
    eidx = 0;
    elat = 0;
    if (v == 0) begin
      efib = 1'b1;
      return;
    end
    for (int j = 47; j >= 1; j--)
      if (fib_tab[j] == v) begin
        efib = 1'b1;
        eidx = j;
        elat = j;
      end
    if (efib) return;
    for (int j = 1; j <= 47; j++)
      if (fib_tab[j] < v) eidx = j;
    elat = (v > fib_tab[47]) ? 47 : eidx + 1;
  endfunction

  task automatic wait_done(input int base, output int n);
    n = base;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic run(input logic [31:0] v, input string tag);
    logic efib;
    int   eidx, elat, n;
    ref_model(longint'(v), efib, eidx, elat);
    @(negedge clock);
    bus.start = 1'b1;
    bus.value = v;
    @(posedge clock); #1;
    bus.start = 1'b0;
    if (v != 0) begin
      chk($sformatf("%s busy", tag), bus.busy, 1);
      chk($sformatf("%s held_fib", tag), bus.is_fib, last_fib);
    end else
      chk($sformatf("%s busy0", tag), bus.busy, 0);
    wait_done(0, n);
    chk($sformatf("%s latency", tag), n, elat);
    chk($sformatf("%s is_fib", tag), bus.is_fib, efib);
    chk($sformatf("%s index", tag), bus.index, eidx);
    chk($sformatf("%s busy_at_done", tag), bus.busy, 0);
    @(posedge clock); #1;
    chk($sformatf("%s done_pulse", tag), bus.done, 0);
    chk($sformatf("%s index_hold", tag), bus.index, eidx);
    last_fib = efib;
    last_idx = eidx;
  endtask

  initial begin
    int   n;
    logic seen;
    fib_tab[0] = 0;
    fib_tab[1] = 1;
    for (int i = 2; i <= 48; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];
    bus.start = 1'b0;
    bus.value = '0;
`ifdef FIB_INDEX_ABORT_EN
    bus.abort = 1'b0;
`endif
    #12;
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset is_fib", bus.is_fib, 0);
    chk("reset index", bus.index, 0);
    @(negedge clock);
    rst = 1'b1;

    run(32'd0, "zero");
    run(32'd1, "one");
    run(32'd8, "eight");
    run(32'd4, "four");
    run(32'd2971215073, "f47");
    run(32'hFFFFFFFF, "overflow");
    run(32'd2, "two");

    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = 32'(fib_tab[$urandom_range(1, 47)]);
        2:       v = 32'(fib_tab[$urandom_range(3, 46)] + 1);
        default: v = $urandom_range(0, 300);
      endcase
      run(v, $sformatf("rand%0d_%0d", i, v));
    end

    // start during a search must be ignored
    @(negedge clock);
    bus.start = 1'b1;
    bus.value = 32'd144;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    bus.start = 1'b1;
    bus.value = 32'd13;
    @(posedge clock); #1;
    bus.start = 1'b0;
    wait_done(3, n);
    chk("ignore latency", n, 12);
    chk("ignore is_fib", bus.is_fib, 1);
    chk("ignore index", bus.index, 12);
    bus.start = 1'b1;
    bus.value = 32'd8;
    @(posedge clock); #1;
    bus.start = 1'b0;
    chk("b2b busy", bus.busy, 1);
    wait_done(0, n);
    chk("b2b latency", n, 6);
    chk("b2b index", bus.index, 6);
    @(posedge clock); #1;

    // asynchronous reset mid-search
    @(negedge clock);
    bus.start = 1'b1;
    bus.value = 32'd144;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clock);
    #2 rst = 1'b0;
    #1;
    chk("arst busy", bus.busy, 0);
    chk("arst is_fib", bus.is_fib, 0);
    chk("arst index", bus.index, 0);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clock); #1;
      seen |= bus.done;
    end
    @(negedge clock);
    rst = 1'b1;
    repeat (15) begin
      @(posedge clock); #1;
      seen |= bus.done;
    end
    chk("arst no_done", seen, 0);
    last_fib = 1'b0;
    last_idx = 0;
    run(32'd21, "post_reset");

`ifdef FIB_INDEX_ABORT_EN
    @(negedge clock);
    bus.start = 1'b1;
    bus.value = 32'd144;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    bus.abort = 1'b1;
    @(posedge clock); #1;
    bus.abort = 1'b0;
    chk("abort busy", bus.busy, 0);
    seen = bus.done;
    repeat (20) begin
      @(posedge clock); #1;
      seen |= bus.done;
    end
    chk("abort no_done", seen, 0);
    chk("abort is_fib", bus.is_fib, 1);
    chk("abort index", bus.index, 8);
    @(negedge clock);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.value = 32'd5;
    @(posedge clock); #1;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort_idle busy", bus.busy, 1);
    wait_done(0, n);
    chk("abort_idle latency", n, 5);
    chk("abort_idle index", bus.index, 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
